// File: rtl/fetch_queue_if.sv
// Fetch front-end signal bundle: instruction bus request/response, redirect, and decode-side queue head.
// The master modport is the fetch_queue side; slave is the bus/decode environment.
interface fetch_queue_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    modport master (
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        output iresp_addr_ok, iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: pipelined sequential ibus requests, PC-tagged instruction FIFO,
// and branch-redirect flush that discards responses to requests issued before the redirect.
module fetch_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter logic [31:0] RESET_PC     = 32'hbfc0_0000
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int SUM_W = CNT_W + INF_W + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STALE = 1'b1;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [31:0]      target_q, target_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic [INF_W-1:0] drop_q, drop_d;
    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [63:0]      mem_q [DEPTH];

    logic [SUM_W-1:0] credit_use;
    logic             credit_ok;
    logic             req_valid;
    logic             accept;
    logic             held;
    logic             drop_hit;
    logic             push;
    logic             pop;

    // Dropped responses still occupy bus slots but will never land in the FIFO, so they do not consume space.
    assign credit_use = SUM_W'(count_q) + SUM_W'(inflight_q) - SUM_W'(drop_q);
    assign credit_ok  = (inflight_q < INF_W'(MAX_INFLIGHT)) && (credit_use < SUM_W'(DEPTH));
    assign req_valid  = ~reset & ((state_q == STALE) | credit_ok);
    assign accept     = req_valid & bus.iresp_addr_ok;
    assign held       = req_valid & ~bus.iresp_addr_ok;
    assign drop_hit   = bus.iresp_data_ok & (drop_q != '0);
    assign push       = bus.iresp_data_ok & ~drop_hit & ~bus.redirect_valid;
    assign pop        = (count_q != '0) & bus.out_ready & ~bus.redirect_valid;

    assign bus.ireq_valid = req_valid;
    assign bus.ireq_addr  = pc_q;
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_pc     = mem_q[rd_ptr_q][63:32];
    assign bus.out_instr  = mem_q[rd_ptr_q][31:0];

    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        target_d   = target_q;
        count_d    = count_q;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q + INF_W'(accept) - INF_W'(bus.iresp_data_ok);
        drop_d     = drop_q;
        if (bus.redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            resp_pc_d = bus.redirect_pc;
            drop_d    = inflight_d;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            if (held) begin
                state_d  = STALE;
                target_d = bus.redirect_pc;
            end else begin
                pc_d    = bus.redirect_pc;
                state_d = RUN;
            end
        end else begin
            drop_d  = drop_q + INF_W'(accept && (state_q == STALE)) - INF_W'(drop_hit);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (accept) begin
                if (state_q == STALE) begin
                    pc_d    = target_q;
                    state_d = RUN;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            target_q   <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            assert (!(push && (count_q == CNT_W'(DEPTH))));
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            target_q   <= target_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {resp_pc_q, bus.iresp_data};
        end
    end
endmodule
